// File: rtl/watchdog_multi.sv
// Multi-channel watchdog: one shared tick prescaler and one independent channel
// per supervised processor. Each channel fires a fixed-length active-low reset
// pulse on timeout or on a kick that arrives before the minimum window.

module watchdog_multi_ch #(
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 4,
    parameter int WINDOW_MIN = 0,
    parameter int RST_LEN    = 16
) (
    input  logic             SNKCLK11,
    input  logic             PSTRESET,
    input  logic             en,
    input  logic             nKick,
    input  logic             clrStatus,
    input  logic             tick,
    output logic             nWdReset,
    output logic             timeoutFlag,
    output logic             earlyFlag,
    output logic [CNT_W-1:0] cnt
);
    localparam int RC_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIRE} chState_e;

    chState_e         state, stateNext;
    logic [CNT_W-1:0] cntNext;
    logic [RC_W-1:0]  rstCnt, rstCntNext;
    logic             kickQ, kick, inWindow, nWdResetNext, setTimeout, setEarly;

    // Falling edge of nKick only; a held-low kick counts once.
    assign kick = kickQ & ~nKick;

    generate
        if (WINDOW_MIN > 0) begin : gWin
            assign inWindow = (cnt < CNT_W'(WINDOW_MIN));
        end else begin : gNoWin
            assign inWindow = 1'b0;
        end
    endgenerate

    // State, counters, pulse output and sticky flags; a same-cycle set beats clear.
    always_ff @(posedge SNKCLK11) begin
        if (PSTRESET) begin
            state       <= en ? RUN : IDLE;
            cnt         <= '0;
            rstCnt      <= '0;
            kickQ       <= 1'b1;
            nWdReset    <= 1'b1;
            timeoutFlag <= 1'b0;
            earlyFlag   <= 1'b0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            rstCnt      <= rstCntNext;
            kickQ       <= nKick;
            nWdReset    <= nWdResetNext;
            timeoutFlag <= (timeoutFlag & ~clrStatus) | setTimeout;
            earlyFlag   <= (earlyFlag & ~clrStatus) | setEarly;
        end
    end

    // Next state: RUN priority is disable, early kick, kick, timeout, count.
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        rstCntNext   = rstCnt;
        nWdResetNext = nWdReset;
        setTimeout   = 1'b0;
        setEarly     = 1'b0;
        unique case (state)
            IDLE: begin
                cntNext = '0;
                if (en) stateNext = RUN;
            end
            RUN: begin
                if (!en) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (kick && inWindow) begin
                    setEarly = 1'b1;
                end else if (kick) begin
                    cntNext = '0;
                end else if (tick && (cnt == CNT_W'(TIMEOUT - 1))) begin
                    setTimeout = 1'b1;
                end else if (tick) begin
                    cntNext = cnt + 1'b1;
                end
            end
            FIRE: begin
                if (rstCnt == RC_W'(RST_LEN - 1)) begin
                    nWdResetNext = 1'b1;
                    cntNext      = '0;
                    stateNext    = en ? RUN : IDLE;
                end else begin
                    rstCntNext = rstCnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
        // Entering FIRE: pulse goes low on this same edge.
        if (setTimeout || setEarly) begin
            stateNext    = FIRE;
            nWdResetNext = 1'b0;
            rstCntNext   = '0;
            cntNext      = '0;
        end
    end
endmodule

module watchdog_multi #(
    parameter int CHANNELS   = 2,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 4,
    parameter int WINDOW_MIN = 0,
    parameter int PRESCALE   = 1,
    parameter int RST_LEN    = 16
) (
    input  logic                      SNKCLK11,
    input  logic                      PSTRESET,
    input  logic [CHANNELS-1:0]       EN,
    input  logic [CHANNELS-1:0]       nWDKICK,
    input  logic                      CLR_STATUS,
    output logic [CHANNELS-1:0]       nWDRESET,
    output logic                      nWDRESET_ALL,
    output logic [CHANNELS-1:0]       TIMEOUT_FLAG,
    output logic [CHANNELS-1:0]       EARLY_FLAG,
    output logic [CHANNELS*CNT_W-1:0] CNT
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] prescaler;
    logic            tick;

    // With PRESCALE=1 the prescaler sits at 0 and tick is always high.
    assign tick = (prescaler == PS_W'(PRESCALE - 1));

    // Shared tick prescaler.
    always_ff @(posedge SNKCLK11) begin
        if (PSTRESET || tick) prescaler <= '0;
        else                  prescaler <= prescaler + 1'b1;
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : gCh
            watchdog_multi_ch #(
                .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .WINDOW_MIN(WINDOW_MIN), .RST_LEN(RST_LEN)
            ) uCh (
                .SNKCLK11   (SNKCLK11),
                .PSTRESET   (PSTRESET),
                .en         (EN[i]),
                .nKick      (nWDKICK[i]),
                .clrStatus  (CLR_STATUS),
                .tick       (tick),
                .nWdReset   (nWDRESET[i]),
                .timeoutFlag(TIMEOUT_FLAG[i]),
                .earlyFlag  (EARLY_FLAG[i]),
                .cnt        (CNT[i*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign nWDRESET_ALL = &nWDRESET;
endmodule
